// File: rtl/rvx_bus_pkg.sv
// Shared types for the two-master RVX bus arbiter: arbiter states,
// master index constants and the layout of one buffered request.
package rvx_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_M0 = 2'd1,
      BUSY_M1 = 2'd2
   } bus_state_t;

   localparam int M_DATA  = 0;
   localparam int M_INSTR = 1;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] address;
      logic [31:0] wdata;
      logic [3:0]  wstrobe;
   } pend_req_t;

endpackage

// File: rtl/rvx_bus_request_buffer.sv
// One-entry holding register for a request pulse that could not be
// forwarded to the slave in the cycle it arrived.
module rvx_bus_request_buffer
   import rvx_bus_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        capture,
   input  logic        clear,
   input  logic        req_write,
   input  logic [31:0] req_address,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrobe,
   output logic        valid,
   output logic        write,
   output logic [31:0] address,
   output logic [31:0] wdata,
   output logic [3:0]  wstrobe
);

   pend_req_t entry;

   // A capture never coincides with a clear for the same master, but capture wins if it did.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         entry <= '0;
      end else if (capture) begin
         entry <= '{valid: 1'b1, write: req_write, address: req_address,
                    wdata: req_wdata, wstrobe: req_wstrobe};
      end else if (clear) begin
         entry.valid <= 1'b0;
      end
   end

   assign valid   = entry.valid;
   assign write   = entry.write;
   assign address = entry.address;
   assign wdata   = entry.wdata;
   assign wstrobe = entry.wstrobe;

endmodule

// File: rtl/rvx_bus_arbiter.sv
// Shares one single-port slave bus between the RVX data bus (master 0)
// and instruction bus (master 1), one outstanding transaction at a time.
module rvx_bus_arbiter
   import rvx_bus_pkg::*;
#(
   parameter bit FAIR = 1'b1
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] m0_address,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrobe,
   input  logic        m0_rrequest,
   input  logic        m0_wrequest,
   output logic [31:0] m0_rdata,
   output logic        m0_rresponse,
   output logic        m0_wresponse,
   input  logic [31:0] m1_address,
   input  logic        m1_rrequest,
   output logic [31:0] m1_rdata,
   output logic        m1_rresponse,
   output logic [31:0] s_address,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrobe,
   output logic        s_rrequest,
   output logic        s_wrequest,
   input  logic [31:0] s_rdata,
   input  logic        s_rresponse,
   input  logic        s_wresponse,
   output logic        protocol_error
);

   bus_state_t  state, state_next;
   logic        last_grant, last_grant_next;
   logic        error_set;

   logic        pend0_valid, pend0_write;
   logic [31:0] pend0_address, pend0_wdata;
   logic [3:0]  pend0_wstrobe;
   logic        pend1_valid, pend1_write;
   logic [31:0] pend1_address, pend1_wdata;
   logic [3:0]  pend1_wstrobe;
   logic        unused_pend1_fields;

   logic        m0_live, m1_live, own0, own1, acc0, acc1;
   logic        cand0, cand1, tie, grant0, grant1;
   logic        capture0, capture1, clear0, clear1, resp_any;
   logic        src0_write;
   logic [31:0] src0_address, src0_wdata, src1_address;
   logic [3:0]  src0_wstrobe;

   // A live request is dropped when its master already has one in flight.
   assign m0_live  = m0_rrequest | m0_wrequest;
   assign m1_live  = m1_rrequest;
   assign own0     = (state == BUSY_M0);
   assign own1     = (state == BUSY_M1);
   assign acc0     = m0_live & ~pend0_valid & ~own0;
   assign acc1     = m1_live & ~pend1_valid & ~own1;
   assign resp_any = s_rresponse | s_wresponse;

   assign cand0  = (state == IDLE) & (pend0_valid | acc0);
   assign cand1  = (state == IDLE) & (pend1_valid | acc1);
   assign tie    = cand0 & cand1;
   assign grant0 = cand0 & (~cand1 | ~FAIR | last_grant);
   assign grant1 = cand1 & ~grant0;

   assign src0_write   = pend0_valid ? pend0_write   : m0_wrequest;
   assign src0_address = pend0_valid ? pend0_address : m0_address;
   assign src0_wdata   = pend0_valid ? pend0_wdata   : m0_wdata;
   assign src0_wstrobe = pend0_valid ? pend0_wstrobe : m0_wstrobe;
   assign src1_address = pend1_valid ? pend1_address : m1_address;

   assign capture0 = acc0 & ~(grant0 & ~pend0_valid);
   assign capture1 = acc1 & ~(grant1 & ~pend1_valid);
   assign clear0   = own0 & resp_any;
   assign clear1   = own1 & resp_any;

   assign error_set = (m0_rrequest & m0_wrequest)
                    | (m0_live & ~acc0)
                    | (m1_live & ~acc1)
                    | ((state == IDLE) & resp_any)
                    | (own1 & s_wresponse);

   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;

   assign unused_pend1_fields = ^{pend1_write, pend1_wdata, pend1_wstrobe};

   rvx_bus_request_buffer u_pend0 (
      .clock       (clock),
      .reset_n     (reset_n),
      .capture     (capture0),
      .clear       (clear0),
      .req_write   (m0_wrequest),
      .req_address (m0_address),
      .req_wdata   (m0_wdata),
      .req_wstrobe (m0_wstrobe),
      .valid       (pend0_valid),
      .write       (pend0_write),
      .address     (pend0_address),
      .wdata       (pend0_wdata),
      .wstrobe     (pend0_wstrobe)
   );

   rvx_bus_request_buffer u_pend1 (
      .clock       (clock),
      .reset_n     (reset_n),
      .capture     (capture1),
      .clear       (clear1),
      .req_write   (1'b0),
      .req_address (m1_address),
      .req_wdata   (32'd0),
      .req_wstrobe (4'd0),
      .valid       (pend1_valid),
      .write       (pend1_write),
      .address     (pend1_address),
      .wdata       (pend1_wdata),
      .wstrobe     (pend1_wstrobe)
   );

   // last_grant starts at 1 so master 0 wins the first tie after reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         protocol_error <= 1'b0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         if (error_set) begin
            protocol_error <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      s_address       = '0;
      s_wdata         = '0;
      s_wstrobe       = '0;
      s_rrequest      = 1'b0;
      s_wrequest      = 1'b0;
      m0_rresponse    = 1'b0;
      m0_wresponse    = 1'b0;
      m1_rresponse    = 1'b0;

      case (state)
         IDLE: begin
            if (grant0) begin
               s_address  = src0_address;
               s_wdata    = src0_wdata;
               s_wstrobe  = src0_wstrobe;
               s_wrequest = src0_write;
               s_rrequest = ~src0_write;
               state_next = BUSY_M0;
            end else if (grant1) begin
               s_address  = src1_address;
               s_rrequest = 1'b1;
               state_next = BUSY_M1;
            end
            if (tie) begin
               last_grant_next = grant1;
            end
         end
         BUSY_M0: begin
            m0_rresponse = s_rresponse;
            m0_wresponse = s_wresponse;
            if (resp_any) begin
               state_next = IDLE;
            end
         end
         BUSY_M1: begin
            m1_rresponse = s_rresponse;
            if (resp_any) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // The register stage resets on this edge; keep the bus quiet meanwhile.
      if (!reset_n) begin
         s_address    = '0;
         s_wdata      = '0;
         s_wstrobe    = '0;
         s_rrequest   = 1'b0;
         s_wrequest   = 1'b0;
         m0_rresponse = 1'b0;
         m0_wresponse = 1'b0;
         m1_rresponse = 1'b0;
      end
   end

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Directed bench for rvx_bus_arbiter: a latency-configurable slave model
// and scoreboard queues for issued requests and returned responses.
module tb_rvx_bus_arbiter;

   typedef struct {
      int          cycle;
      logic [31:0] address;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrobe;
   } req_exp_t;

   typedef struct {
      int          cycle;
      int          master;
      logic        write;
      logic [31:0] rdata;
   } resp_exp_t;

   typedef struct {
      int          cycle;
      logic [31:0] address;
   } fix_exp_t;

   logic        clock, reset_n;
   logic [31:0] m0_address, m0_wdata, m1_address;
   logic [3:0]  m0_wstrobe;
   logic        m0_rrequest, m0_wrequest, m1_rrequest;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_rresponse, m0_wresponse, m1_rresponse;
   logic [31:0] s_address, s_wdata, s_rdata;
   logic [3:0]  s_wstrobe;
   logic        s_rrequest, s_wrequest, s_rresponse, s_wresponse;
   logic        protocol_error;

   logic [31:0] f_m0_rdata, f_m1_rdata, f_s_address, f_s_wdata;
   logic [3:0]  f_s_wstrobe;
   logic        f_m0_rresponse, f_m0_wresponse, f_m1_rresponse;
   logic        f_s_rrequest, f_s_wrequest, f_protocol_error;

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          slave_latency = 1;
   int          slave_count = 0;
   bit          slave_busy = 0;
   logic        slave_write = 0;
   logic [31:0] slave_addr = '0;

   req_exp_t    req_q[$];
   resp_exp_t   resp_q[$];
   fix_exp_t    fix_q[$];
   req_exp_t    re;
   resp_exp_t   rp;
   fix_exp_t    fe;

   rvx_bus_arbiter #(.FAIR(1'b1)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_wstrobe(m0_wstrobe),
      .m0_rrequest(m0_rrequest), .m0_wrequest(m0_wrequest),
      .m0_rdata(m0_rdata), .m0_rresponse(m0_rresponse), .m0_wresponse(m0_wresponse),
      .m1_address(m1_address), .m1_rrequest(m1_rrequest),
      .m1_rdata(m1_rdata), .m1_rresponse(m1_rresponse),
      .s_address(s_address), .s_wdata(s_wdata), .s_wstrobe(s_wstrobe),
      .s_rrequest(s_rrequest), .s_wrequest(s_wrequest),
      .s_rdata(s_rdata), .s_rresponse(s_rresponse), .s_wresponse(s_wresponse),
      .protocol_error(protocol_error)
   );

   // Fixed-priority twin fed identical stimulus; it shares the slave timing.
   rvx_bus_arbiter #(.FAIR(1'b0)) u_fixed (
      .clock(clock), .reset_n(reset_n),
      .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_wstrobe(m0_wstrobe),
      .m0_rrequest(m0_rrequest), .m0_wrequest(m0_wrequest),
      .m0_rdata(f_m0_rdata), .m0_rresponse(f_m0_rresponse), .m0_wresponse(f_m0_wresponse),
      .m1_address(m1_address), .m1_rrequest(m1_rrequest),
      .m1_rdata(f_m1_rdata), .m1_rresponse(f_m1_rresponse),
      .s_address(f_s_address), .s_wdata(f_s_wdata), .s_wstrobe(f_s_wstrobe),
      .s_rrequest(f_s_rrequest), .s_wrequest(f_s_wrequest),
      .s_rdata(s_rdata), .s_rresponse(s_rresponse), .s_wresponse(s_wresponse),
      .protocol_error(f_protocol_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc = cyc + 1;

   function automatic logic [31:0] slave_data(input logic [31:0] addr);
      return addr + 32'h13;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_response(input int master, input logic write, input logic [31:0] rdata);
      resp_exp_t e;
      if (resp_q.size() == 0) begin
         check_output("unexpected_response", 64'(master * 2 + int'(write)), 64'hFF);
      end else begin
         e = resp_q.pop_front();
         check_output("resp_master_kind", 64'(master * 2 + int'(write)),
                      64'(e.master * 2 + int'(e.write)));
         check_output("resp_cycle", 64'(cyc), 64'(e.cycle));
         if (!e.write) check_output("resp_rdata", 64'(rdata), 64'(e.rdata));
      end
   endtask

   // Slave model: records a request at mid-cycle, answers slave_latency cycles later.
   always @(negedge clock) begin
      if (!reset_n) begin
         slave_busy = 0;
      end else if (s_rrequest || s_wrequest) begin
         slave_busy  = 1;
         slave_count = slave_latency;
         slave_write = s_wrequest;
         slave_addr  = s_address;
      end
   end

   initial begin
      s_rresponse = 0;
      s_wresponse = 0;
      s_rdata     = '0;
      forever begin
         @(posedge clock);
         #1;
         s_rresponse = 0;
         s_wresponse = 0;
         if (slave_busy) begin
            slave_count--;
            if (slave_count == 0) begin
               slave_busy  = 0;
               s_rdata     = slave_write ? 32'h0 : slave_data(slave_addr);
               s_rresponse = ~slave_write;
               s_wresponse = slave_write;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (reset_n) begin
         if (s_rrequest || s_wrequest) begin
            if (req_q.size() == 0) begin
               check_output("unexpected_request", 64'(s_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               re = req_q.pop_front();
               check_output("req_cycle", 64'(cyc), 64'(re.cycle));
               check_output("req_address", 64'(s_address), 64'(re.address));
               check_output("req_kind", 64'({s_wrequest, s_rrequest}), 64'({re.write, ~re.write}));
               check_output("req_wdata", 64'(s_wdata), 64'(re.wdata));
               check_output("req_wstrobe", 64'(s_wstrobe), 64'(re.wstrobe));
            end
         end
         if (m0_rresponse) check_response(0, 1'b0, m0_rdata);
         if (m0_wresponse) check_response(0, 1'b1, m0_rdata);
         if (m1_rresponse) check_response(1, 1'b0, m1_rdata);
         if (f_s_rrequest || f_s_wrequest) begin
            if (fix_q.size() == 0) begin
               check_output("fixed_unexpected_request", 64'(f_s_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               fe = fix_q.pop_front();
               check_output("fixed_cycle", 64'(cyc), 64'(fe.cycle));
               check_output("fixed_address", 64'(f_s_address), 64'(fe.address));
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
      m0_rrequest = 0;
      m0_wrequest = 0;
      m1_rrequest = 0;
   endtask

   task automatic apply_stimulus_m0(input logic write, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrobe);
      m0_address  = addr;
      m0_wdata    = wdata;
      m0_wstrobe  = wstrobe;
      m0_wrequest = write;
      m0_rrequest = ~write;
   endtask

   task automatic apply_stimulus_m1(input logic [31:0] addr);
      m1_address  = addr;
      m1_rrequest = 1;
   endtask

   task automatic push_req(input int cycle, input logic [31:0] addr, input logic [31:0] fixed_addr,
                           input logic write, input logic [31:0] wdata, input logic [3:0] wstrobe);
      req_q.push_back('{cycle: cycle, address: addr, write: write, wdata: wdata, wstrobe: wstrobe});
      fix_q.push_back('{cycle: cycle, address: fixed_addr});
   endtask

   task automatic push_resp(input int cycle, input int master, input logic write, input logic [31:0] rdata);
      resp_q.push_back('{cycle: cycle, master: master, write: write, rdata: rdata});
   endtask

   task automatic drain(input string tag);
      next_cycle();
      for (int i = 0; i < 40; i++) begin
         if (req_q.size() == 0 && resp_q.size() == 0 && fix_q.size() == 0) break;
         next_cycle();
      end
      check_output(tag, 64'(req_q.size() + resp_q.size() + fix_q.size()), 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, "_requests"}, 64'({s_rrequest, s_wrequest, f_s_rrequest, f_s_wrequest}), 64'd0);
      check_output({tag, "_responses"}, 64'({m0_rresponse, m0_wresponse, m1_rresponse}), 64'd0);
      check_output({tag, "_bus"}, {s_address, s_wdata | 32'(s_wstrobe)}, 64'd0);
      check_output({tag, "_error"}, 64'({protocol_error, f_protocol_error}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          c;
      logic [31:0] a0, a1, first, second;
      bit          m1_first;

      reset_n = 0;
      m0_address = '0; m0_wdata = '0; m0_wstrobe = '0;
      m0_rrequest = 0; m0_wrequest = 0;
      m1_address = '0; m1_rrequest = 0;
      next_cycle();
      next_cycle();
      #2;
      check_idle_outputs("reset");
      next_cycle();
      reset_n = 1;
      #2;
      check_idle_outputs("after_reset");

      // Single write forwarded in the same cycle, response one cycle later.
      slave_latency = 1;
      next_cycle();
      c = cyc;
      apply_stimulus_m0(1, 32'h100, 32'hDEADBEEF, 4'hF);
      push_req(c, 32'h100, 32'h100, 1, 32'hDEADBEEF, 4'hF);
      push_resp(c + 1, 0, 1, 32'h0);
      drain("drain_write");

      // First tie after reset: master 0 first, master 1 after a turnaround cycle.
      next_cycle();
      c = cyc;
      apply_stimulus_m0(0, 32'h200, 32'h0, 4'h0);
      apply_stimulus_m1(32'h000);
      push_req(c, 32'h200, 32'h200, 0, 0, 0);
      push_req(c + 2, 32'h000, 32'h000, 0, 0, 0);
      push_resp(c + 1, 0, 0, slave_data(32'h200));
      push_resp(c + 3, 1, 0, 32'h00000013);
      drain("drain_tie");

      // Repeated ties alternate in the round-robin unit; the twin always serves m0 first.
      for (int k = 0; k < 4; k++) begin
         a0 = 32'h300 + 32'(k * 16);
         a1 = 32'h400 + 32'(k * 16);
         m1_first = (k % 2 == 0);
         first  = m1_first ? a1 : a0;
         second = m1_first ? a0 : a1;
         next_cycle();
         c = cyc;
         apply_stimulus_m0(0, a0, 32'h0, 4'h0);
         apply_stimulus_m1(a1);
         push_req(c, first, a0, 0, 0, 0);
         push_req(c + 2, second, a1, 0, 0, 0);
         push_resp(c + 1, m1_first ? 1 : 0, 0, slave_data(first));
         push_resp(c + 3, m1_first ? 0 : 1, 0, slave_data(second));
         drain("drain_rr");
      end

      // Master 1 arrives while master 0 owns a slow slave.
      slave_latency = 3;
      next_cycle();
      c = cyc;
      apply_stimulus_m0(0, 32'h500, 32'h0, 4'h0);
      push_req(c, 32'h500, 32'h500, 0, 0, 0);
      push_resp(c + 3, 0, 0, slave_data(32'h500));
      push_req(c + 4, 32'h600, 32'h600, 0, 0, 0);
      push_resp(c + 7, 1, 0, slave_data(32'h600));
      next_cycle();
      apply_stimulus_m1(32'h600);
      drain("drain_buffered");
      check_output("no_error_buffered", 64'({protocol_error, f_protocol_error}), 64'd0);

      // Second request from master 0 while it owns the bus is dropped.
      next_cycle();
      c = cyc;
      apply_stimulus_m0(0, 32'h700, 32'h0, 4'h0);
      push_req(c, 32'h700, 32'h700, 0, 0, 0);
      push_resp(c + 3, 0, 0, slave_data(32'h700));
      next_cycle();
      apply_stimulus_m0(1, 32'h704, 32'h12345678, 4'h3);
      drain("drain_drop");
      check_output("error_set", 64'({protocol_error, f_protocol_error}), 64'd3);
      next_cycle();
      next_cycle();
      #2;
      check_output("error_sticky", 64'({protocol_error, f_protocol_error}), 64'd3);

      // Reset while master 1 owns the bus and master 0 has a buffered request.
      slave_latency = 5;
      next_cycle();
      c = cyc;
      apply_stimulus_m1(32'h800);
      push_req(c, 32'h800, 32'h800, 0, 0, 0);
      next_cycle();
      apply_stimulus_m0(0, 32'h900, 32'h0, 4'h0);
      next_cycle();
      reset_n = 0;
      #2;
      check_output("reset_mid_requests", 64'({s_rrequest, m1_rresponse}), 64'd0);
      next_cycle();
      reset_n = 1;
      #2;
      check_idle_outputs("post_reset");
      for (int i = 0; i < 6; i++) next_cycle();
      check_output("pend_cleared", 64'(req_q.size() + resp_q.size() + fix_q.size()), 64'd0);

      // The first tie after a reset goes to master 0 again.
      slave_latency = 1;
      next_cycle();
      c = cyc;
      apply_stimulus_m0(0, 32'hB00, 32'h0, 4'h0);
      apply_stimulus_m1(32'hC00);
      push_req(c, 32'hB00, 32'hB00, 0, 0, 0);
      push_req(c + 2, 32'hC00, 32'hC00, 0, 0, 0);
      push_resp(c + 1, 0, 0, slave_data(32'hB00));
      push_resp(c + 3, 1, 0, slave_data(32'hC00));
      drain("drain_final");
      check_output("final_error", 64'({protocol_error, f_protocol_error}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
